mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_abs.sv | 20 ++
 rtl/mul_div_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states, op-class helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mdu_abs.sv
// Two's-complement magnitude and sign of one operand (sign ignored when i_signed is low).
// Latency: combinational.
// Backpressure: none.
module mdu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_neg
);

    logic w_neg;

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_neg = i_signed & i_val[WIDTH-1];
    assign o_mag = w_neg ? -i_val : i_val;
    assign o_neg = w_neg;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Latency: WIDTH+3 edges from accepted iStart to oDone; MTHI/MTLO complete on the sampling edge.
// Backpressure: iStart is dropped while oBusy is high; iFlush squashes any in-flight operation.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);
    import mdu_pkg::*;

    state_e             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_is_mul = op_is_mul(r_op);
    assign w_sgn    = op_is_signed(r_op);

    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_val    (r_a),
        .i_signed (w_sgn),
        .o_mag    (w_mag_a),
        .o_neg    (w_neg_a)
    );

    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_val    (r_b),
        .i_signed (w_sgn),
        .o_mag    (w_mag_b),
        .o_neg    (w_neg_b)
    );

    // Multiply: r_quo holds the multiplier, shifted out LSB-first while the partial product shifts in.
    assign w_sum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    // Divide: r_quo holds the dividend, shifted out MSB-first while quotient bits shift in.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

    assign w_prod   = {r_rem, r_quo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_s[WIDTH-1:0];
        if (!w_is_mul) begin
            if (r_dz) begin
                w_fix_hi = r_a;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_r ? -r_rem : r_rem;
                w_fix_lo = r_neg_q ? -r_quo : r_quo;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_opnd  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            if (iFlush) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (iStart) begin
                            case (iOp)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    r_a     <= iA;
                                    r_b     <= iB;
                                    r_op    <= iOp;
                                    r_busy  <= 1'b1;
                                    r_state <= ST_PREP;
                                end
                                OP_MTHI: begin
                                    r_hi   <= iA;
                                    r_done <= 1'b1;
                                end
                                OP_MTLO: begin
                                    r_lo   <= iA;
                                    r_done <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_PREP: begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_is_mul ? w_mag_b : w_mag_a;
                        r_opnd  <= w_is_mul ? w_mag_a : w_mag_b;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_dz    <= (r_b == '0);
                        r_state <= ST_CALC;
                    end
                    ST_CALC: begin
                        if (r_cnt == CNT_W'(WIDTH)) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_is_mul) begin
                                {r_rem, r_quo} <= {w_sum, r_quo[WIDTH-1:1]};
                            end else begin
                                r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                                r_quo <= {r_quo[WIDTH-2:0], w_ge};
                            end
                        end
                    end
                    ST_FIX: begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign oBusy = r_busy;
    assign oDone = r_done;
    assign oHI   = r_hi;
    assign oLO   = r_lo;

endmodule
